// File: rtl/vend_pkg.sv
// Shared coin-escrow types: denomination values, FSM state encoding and
// clamping arithmetic helpers used by the escrow/bank counters.
package vend_pkg;
    localparam int MAX_COIN = 4;
    localparam int COIN_VAL [MAX_COIN] = '{1, 5, 10, 20};

    typedef enum logic [1:0] {IDLE, COLLECT, READY, REFUND} state_t;

    // b may be negative; the result is clamped to [0, maxv]
    function automatic int sat_add(input int a, input int b, input int maxv);
        int s;
        s = a + b;
        if (s < 0)
            s = 0;
        else if (s > maxv)
            s = maxv;
        return s;
    endfunction

    function automatic int sat_sub(input int a, input int b, input int maxv);
        return sat_add(a, -b, maxv);
    endfunction
endpackage

// File: rtl/coin_escrow_counter.sv
// One denomination: escrow coin counter plus bank counter with a combined
// clamp(bank + esc*commit - wd*wd_valid, 0, max) update.
module coin_counter
    import vend_pkg::*;
#(
    parameter int ESC_W  = 3,
    parameter int BANK_W = 6
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              i_inc,
    input  logic              i_clr,
    input  logic              i_commit,
    input  logic              i_wd_valid,
    input  logic [BANK_W-1:0] i_wd,
    output logic [ESC_W-1:0]  o_esc,
    output logic [BANK_W-1:0] o_bank
);
    localparam int ESC_MAX  = 2**ESC_W - 1;
    localparam int BANK_MAX = 2**BANK_W - 1;

    logic [ESC_W-1:0]  r_esc;
    logic [BANK_W-1:0] r_bank;
    int                w_delta;

    // Commit and withdraw are netted before clamping so neither limit is hit early
    always_comb begin
        w_delta = 0;
        if (i_commit)
            w_delta = w_delta + int'(r_esc);
        if (i_wd_valid)
            w_delta = w_delta - int'(i_wd);
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_esc  <= '0;
            r_bank <= '0;
        end else begin
            if (i_clr)
                r_esc <= '0;
            else if (i_inc)
                r_esc <= ESC_W'(sat_add(int'(r_esc), 1, ESC_MAX));
            if (i_commit || i_wd_valid)
                r_bank <= BANK_W'(sat_add(int'(r_bank), w_delta, BANK_MAX));
        end
    end

    assign o_esc  = r_esc;
    assign o_bank = r_bank;
endmodule

// File: rtl/coin_escrow.sv
// Vending-machine coin intake: escrow, price check, commit-to-bank and refund
// handshake. Optional COLLECT inactivity timeout under `COIN_TIMEOUT_EN.
module coin_escrow
    import vend_pkg::*;
#(
    parameter int NUM_COIN    = 4,
    parameter int SUM_W       = 8,
    parameter int ESC_W       = 3,
    parameter int BANK_W      = 6,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                       clk,
    input  logic                       i_rst,
    input  logic [NUM_COIN-1:0]        i_coin,
    input  logic [SUM_W-1:0]           i_price,
    input  logic                       i_commit,
    input  logic                       i_refund,
    input  logic                       i_ret_ack,
    input  logic                       i_wd_valid,
    input  logic [NUM_COIN*BANK_W-1:0] i_wd_cnt,
    output logic [NUM_COIN*ESC_W-1:0]  o_esc_cnt,
    output logic [NUM_COIN*BANK_W-1:0] o_bank_cnt,
    output logic [SUM_W-1:0]           o_sum,
    output logic                       o_enough,
    output logic                       o_ret_valid,
    output logic                       o_reject,
    output logic                       o_done
);
    localparam int SUM_MAX = 2**SUM_W - 1;

    state_t              r_state;
    logic [SUM_W-1:0]    r_sum;
    logic                r_ack_d;
    logic [NUM_COIN-1:0] w_inc;
    logic                w_room;
    logic                w_coin_ok;
    logic                w_commit;
    logic                w_ret_done;
    logic                w_clr;
    logic                w_timeout;
    int                  w_val;

    always_comb begin
        w_val  = 0;
        w_room = 1'b0;
        for (int k = 0; k < NUM_COIN; k++) begin
            if (i_coin[k]) begin
                w_val  = COIN_VAL[k];
                w_room = (o_esc_cnt[k*ESC_W +: ESC_W] != {ESC_W{1'b1}});
            end
        end
    end

    assign w_coin_ok  = ((r_state == IDLE) || (r_state == COLLECT)) && $onehot(i_coin)
                        && w_room && ((int'(r_sum) + w_val) <= SUM_MAX);
    assign w_inc      = w_coin_ok ? i_coin : '0;
    assign w_commit   = (r_state == READY) && i_commit && !i_refund;
    // A held ack counts once: only its rising edge releases the escrow
    assign w_ret_done = (r_state == REFUND) && i_ret_ack && !r_ack_d;
    assign w_clr      = w_commit || w_ret_done;

`ifdef COIN_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] r_to_cnt;

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst)
            r_to_cnt <= '0;
        else if ((r_state != COLLECT) || w_coin_ok)
            r_to_cnt <= '0;
        else if (r_to_cnt != TO_W'(TIMEOUT_CYC))
            r_to_cnt <= r_to_cnt + TO_W'(1);
    end

    assign w_timeout = (r_state == COLLECT) && (r_to_cnt == TO_W'(TIMEOUT_CYC));
`else
    // No inactivity limit: COLLECT waits for the price or a refund
    assign w_timeout = (TIMEOUT_CYC < 0);
`endif

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_sum       <= '0;
            r_ack_d     <= 1'b0;
            o_enough    <= 1'b0;
            o_ret_valid <= 1'b0;
            o_reject    <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            r_ack_d  <= i_ret_ack;
            o_reject <= (|i_coin) && !w_coin_ok;
            o_done   <= w_commit;
            if (w_clr)
                r_sum <= '0;
            else if (w_coin_ok)
                r_sum <= r_sum + SUM_W'(w_val);
            case (r_state)
                IDLE: begin
                    if (w_coin_ok)
                        r_state <= COLLECT;
                end
                COLLECT: begin
                    if (i_refund || w_timeout) begin
                        r_state     <= REFUND;
                        o_ret_valid <= 1'b1;
                    end else if (r_sum >= i_price) begin
                        r_state  <= READY;
                        o_enough <= 1'b1;
                    end
                end
                READY: begin
                    if (i_refund) begin
                        r_state     <= REFUND;
                        o_enough    <= 1'b0;
                        o_ret_valid <= 1'b1;
                    end else if (i_commit) begin
                        r_state  <= IDLE;
                        o_enough <= 1'b0;
                    end
                end
                REFUND: begin
                    if (w_ret_done) begin
                        r_state     <= IDLE;
                        o_ret_valid <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_sum = r_sum;

    for (genvar k = 0; k < NUM_COIN; k++) begin : g_coin
        coin_counter #(
            .ESC_W (ESC_W),
            .BANK_W(BANK_W)
        ) u_cnt (
            .clk       (clk),
            .i_rst     (i_rst),
            .i_inc     (w_inc[k]),
            .i_clr     (w_clr),
            .i_commit  (w_commit),
            .i_wd_valid(i_wd_valid),
            .i_wd      (i_wd_cnt[k*BANK_W +: BANK_W]),
            .o_esc     (o_esc_cnt[k*ESC_W +: ESC_W]),
            .o_bank    (o_bank_cnt[k*BANK_W +: BANK_W])
        );
    end
endmodule

// File: tb/tb_coin_escrow.sv
// Directed bench for coin_escrow: a vector table for the single-cycle flow and
// hand sequences for bank saturation, async reset and the COLLECT timeout.
module tb_coin_escrow;
    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [3:0]  i_coin = '0;
    logic [7:0]  i_price = '0;
    logic        i_commit = 1'b0;
    logic        i_refund = 1'b0;
    logic        i_ret_ack = 1'b0;
    logic        i_wd_valid = 1'b0;
    logic [23:0] i_wd_cnt = '0;
    logic [11:0] o_esc_cnt;
    logic [23:0] o_bank_cnt;
    logic [7:0]  o_sum;
    logic        o_enough, o_ret_valid, o_reject, o_done;

    int checks = 0;
    int errors = 0;

    coin_escrow #(
        .NUM_COIN(4), .SUM_W(8), .ESC_W(3), .BANK_W(6), .TIMEOUT_CYC(20)
    ) dut (
        .clk(clk), .i_rst(i_rst), .i_coin(i_coin), .i_price(i_price),
        .i_commit(i_commit), .i_refund(i_refund), .i_ret_ack(i_ret_ack),
        .i_wd_valid(i_wd_valid), .i_wd_cnt(i_wd_cnt), .o_esc_cnt(o_esc_cnt),
        .o_bank_cnt(o_bank_cnt), .o_sum(o_sum), .o_enough(o_enough),
        .o_ret_valid(o_ret_valid), .o_reject(o_reject), .o_done(o_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  coin;
        logic [7:0]  price;
        logic        cmt, rf, ack, wdv;
        logic [23:0] wd;
        logic [11:0] esc;
        logic [23:0] bank;
        logic [7:0]  sum;
        logic [3:0]  flg;   // {enough, ret_valid, reject, done}
    } vec_t;

    vec_t vq[$];

    function automatic logic [11:0] e4(input int a, input int b, input int c, input int d);
        e4 = {d[2:0], c[2:0], b[2:0], a[2:0]};
    endfunction

    function automatic logic [23:0] b4(input int a, input int b, input int c, input int d);
        b4 = {d[5:0], c[5:0], b[5:0], a[5:0]};
    endfunction

    task automatic add(input logic [3:0] coin, input logic [7:0] price, input logic cmt,
                       input logic rf, input logic ack, input logic wdv, input logic [23:0] wd,
                       input logic [11:0] esc, input logic [23:0] bank, input logic [7:0] sum,
                       input logic [3:0] flg);
        vec_t v;
        v.coin = coin; v.price = price; v.cmt = cmt; v.rf = rf; v.ack = ack;
        v.wdv = wdv; v.wd = wd; v.esc = esc; v.bank = bank; v.sum = sum; v.flg = flg;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] flags();
        flags = {o_enough, o_ret_valid, o_reject, o_done};
    endfunction

    // n one-coins at price p, wait for READY, then commit with a bank-0 withdraw
    task automatic round(input int n, input int wd0, input int exp_b0);
        i_price = 8'(n);
        for (int i = 0; i < n; i++) begin
            i_coin = 4'b0001;
            tick();
        end
        i_coin = '0;
        tick();
        chk($sformatf("round%0d ready", exp_b0), {31'd0, o_enough}, 32'd1);
        i_commit = 1'b1;
        i_wd_valid = (wd0 != 0);
        i_wd_cnt = b4(wd0, 0, 0, 0);
        tick();
        i_commit = 1'b0;
        i_wd_valid = 1'b0;
        i_wd_cnt = '0;
        chk($sformatf("round%0d bank", exp_b0), {8'd0, o_bank_cnt}, {8'd0, b4(exp_b0, 1, 0, 0)});
        chk($sformatf("round%0d done", exp_b0), {31'd0, o_done}, 32'd1);
    endtask

    initial begin
        int n;
        // T1/T2: 5,1,1 at price 7 then commit
        add(4'b0010, 7, 0,0,0,0, 0, e4(0,1,0,0), 0, 5, 4'b0000);
        add(4'b0001, 7, 0,0,0,0, 0, e4(1,1,0,0), 0, 6, 4'b0000);
        add(4'b0001, 7, 0,0,0,0, 0, e4(2,1,0,0), 0, 7, 4'b0000);
        add(4'b0000, 7, 0,0,0,0, 0, e4(2,1,0,0), 0, 7, 4'b1000);
        add(4'b0000, 7, 1,0,0,0, 0, 0, b4(2,1,0,0), 0, 4'b0001);
        add(4'b0000, 7, 0,0,0,0, 0, 0, b4(2,1,0,0), 0, 4'b0000);
        // T3: 10,10 at price 30, refund, held five cycles (coin rejected), ack
        add(4'b0100, 30, 0,0,0,0, 0, e4(0,0,1,0), b4(2,1,0,0), 10, 4'b0000);
        add(4'b0100, 30, 0,0,0,0, 0, e4(0,0,2,0), b4(2,1,0,0), 20, 4'b0000);
        add(4'b0000, 30, 0,1,0,0, 0, e4(0,0,2,0), b4(2,1,0,0), 20, 4'b0100);
        add(4'b0000, 30, 0,0,0,0, 0, e4(0,0,2,0), b4(2,1,0,0), 20, 4'b0100);
        add(4'b0000, 30, 0,0,0,0, 0, e4(0,0,2,0), b4(2,1,0,0), 20, 4'b0100);
        add(4'b0001, 30, 0,0,0,0, 0, e4(0,0,2,0), b4(2,1,0,0), 20, 4'b0110);
        add(4'b0000, 30, 1,0,0,0, 0, e4(0,0,2,0), b4(2,1,0,0), 20, 4'b0100);
        add(4'b0000, 30, 0,0,0,0, 0, e4(0,0,2,0), b4(2,1,0,0), 20, 4'b0100);
        add(4'b0000, 30, 0,0,1,0, 0, 0, b4(2,1,0,0), 0, 4'b0000);
        add(4'b0000, 30, 0,0,1,0, 0, 0, b4(2,1,0,0), 0, 4'b0000);
        // T4: two strobes at once, then escrow saturation of the 1-coin
        add(4'b0011, 30, 0,0,0,0, 0, 0, b4(2,1,0,0), 0, 4'b0010);
        add(4'b0000, 30, 0,0,0,0, 0, 0, b4(2,1,0,0), 0, 4'b0000);
        for (int k = 1; k <= 7; k++)
            add(4'b0001, 200, 0,0,0,0, 0, e4(k,0,0,0), b4(2,1,0,0), 8'(k), 4'b0000);
        add(4'b0001, 200, 0,0,0,0, 0, e4(7,0,0,0), b4(2,1,0,0), 7, 4'b0010);
        add(4'b0000, 200, 0,1,0,0, 0, e4(7,0,0,0), b4(2,1,0,0), 7, 4'b0100);
        add(4'b0000, 200, 0,0,1,0, 0, 0, b4(2,1,0,0), 0, 4'b0000);
        // Withdraw floors at zero
        add(4'b0000, 200, 0,0,0,1, b4(3,0,0,0), 0, b4(0,1,0,0), 0, 4'b0000);

        #12;
        chk("reset esc", {20'd0, o_esc_cnt}, 32'd0);
        chk("reset bank", {8'd0, o_bank_cnt}, 32'd0);
        chk("reset sum", {24'd0, o_sum}, 32'd0);
        chk("reset flags", {28'd0, flags()}, 32'd0);
        i_rst = 1'b0;

        foreach (vq[i]) begin
            i_coin = vq[i].coin; i_price = vq[i].price; i_commit = vq[i].cmt;
            i_refund = vq[i].rf; i_ret_ack = vq[i].ack; i_wd_valid = vq[i].wdv;
            i_wd_cnt = vq[i].wd;
            tick();
            chk($sformatf("v%0d esc", i), {20'd0, o_esc_cnt}, {20'd0, vq[i].esc});
            chk($sformatf("v%0d bank", i), {8'd0, o_bank_cnt}, {8'd0, vq[i].bank});
            chk($sformatf("v%0d sum", i), {24'd0, o_sum}, {24'd0, vq[i].sum});
            chk($sformatf("v%0d flags", i), {28'd0, flags()}, {28'd0, vq[i].flg});
        end
        i_coin = '0; i_commit = 0; i_refund = 0; i_ret_ack = 0; i_wd_valid = 0; i_wd_cnt = '0;

        // T5a: commit and refund together in READY -> refund wins
        i_price = 5;
        i_coin = 4'b0010;
        tick();
        i_coin = '0;
        tick();
        chk("t5 ready", {31'd0, o_enough}, 32'd1);
        i_commit = 1'b1;
        i_refund = 1'b1;
        tick();
        i_commit = 1'b0;
        i_refund = 1'b0;
        chk("t5 refund wins", {28'd0, flags()}, 32'b0100);
        chk("t5 bank kept", {8'd0, o_bank_cnt}, {8'd0, b4(0,1,0,0)});
        chk("t5 esc held", {20'd0, o_esc_cnt}, {20'd0, e4(0,1,0,0)});
        i_ret_ack = 1'b1;
        tick();
        i_ret_ack = 1'b0;
        chk("t5 ack clears", {20'd0, o_esc_cnt}, 32'd0);

        // T5b: fill bank[0] to 62, saturate at 63, then net commit+withdraw
        for (int r = 1; r <= 8; r++)
            round(7, 0, 7 * r);
        round(6, 0, 62);
        round(3, 0, 63);
        round(3, 10, 56);

        // Async reset mid-transaction
        i_price = 200;
        i_coin = 4'b0100;
        tick();
        i_coin = '0;
        chk("pre-reset sum", {24'd0, o_sum}, 32'd10);
        #2 i_rst = 1'b1;
        #1;
        chk("async rst sum", {24'd0, o_sum}, 32'd0);
        chk("async rst bank", {8'd0, o_bank_cnt}, 32'd0);
        chk("async rst esc", {20'd0, o_esc_cnt}, 32'd0);
        #10 i_rst = 1'b0;

        // T6: one coin then inactivity
        i_coin = 4'b0001;
        tick();
        i_coin = '0;
`ifdef COIN_TIMEOUT_EN
        n = 0;
        while (!o_ret_valid && n < 40) begin
            tick();
            n++;
        end
        chk("timeout window", {31'd0, (n >= 19 && n <= 22)}, 32'd1);
        chk("timeout esc", {20'd0, o_esc_cnt}, {20'd0, e4(1,0,0,0)});
        i_ret_ack = 1'b1;
        tick();
        i_ret_ack = 1'b0;
        chk("timeout ack", {24'd0, o_sum}, 32'd0);
`else
        n = 0;
        repeat (100) begin
            tick();
            n++;
        end
        chk("no timeout rv", {31'd0, o_ret_valid}, 32'd0);
        chk("no timeout en", {31'd0, o_enough}, 32'd0);
        chk("no timeout sum", {24'd0, o_sum}, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
